// File: rtl/simon_pkg.sv
// Shared definitions for the Simon autoplayer: mode encodings, FSM states,
// buffer geometry and the pattern-generation helpers.
package simon_pkg;

   localparam int unsigned BUF_DEPTH = 64;
   localparam int unsigned ADDR_W    = 6;
   localparam int unsigned PTR_W     = 7;

   localparam logic [2:0] MODE_INPUT    = 3'b001;
   localparam logic [2:0] MODE_PLAYBACK = 3'b010;
   localparam logic [2:0] MODE_REPEAT   = 3'b100;
   localparam logic [2:0] MODE_DONE     = 3'b111;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      DECIDE,
      PRESS_HI,
      PRESS_LO,
      SETTLE,
      FINISH,
      ERROR
   } state_t;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/simon_seq_buf.sv
// Recorded-sequence store: one synchronous write port, one combinational
// read port, contents deliberately left unreset.
module simon_seq_buf
   import simon_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [3:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [3:0]        rdata
);

   logic [3:0] mem [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/simon_autoplayer.sv
// Plays a Simon game automatically: watches Simon's mode/pattern LEDs and
// strobes its clock input with the switch value it should see next.
module simon_autoplayer
   import simon_pkg::*;
#(
   parameter int unsigned HOLD = 4
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] mode_leds,
   input  logic [3:0] pattern_leds,
   output logic       btn_clk,
   output logic [3:0] pattern,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [6:0] rounds
);

   state_t             state_q, state_d;
   logic [3:0]         hold_cnt;
   logic               hold_last;
   logic [2:0]         mode_q;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, in_cnt;
   logic [7:0]         lfsr;
   logic               buf_we;
   logic [3:0]         rd_data;

   simon_seq_buf u_buf (
      .clk   (pclk),
      .we    (buf_we),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (pattern_leds),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (rd_data)
   );

   assign hold_last = (hold_cnt == 4'(HOLD - 1));

   always_comb begin
      state_d = state_q;
      buf_we  = 1'b0;
      case (state_q)
         IDLE:     if (start) state_d = DECIDE;
         DECIDE: begin
            case (mode_leds)
               MODE_INPUT:
                  state_d = (in_cnt == PTR_W'(BUF_DEPTH)) ? ERROR : PRESS_HI;
               MODE_PLAYBACK: begin
                  state_d = (wr_ptr == PTR_W'(BUF_DEPTH)) ? ERROR : PRESS_HI;
                  buf_we  = (wr_ptr != PTR_W'(BUF_DEPTH));
               end
               MODE_REPEAT:
                  state_d = (rd_ptr == wr_ptr) ? ERROR : PRESS_HI;
               MODE_DONE: state_d = FINISH;
               default:   state_d = DECIDE;
            endcase
         end
         PRESS_HI: if (hold_last) state_d = PRESS_LO;
         PRESS_LO: if (hold_last) state_d = SETTLE;
         SETTLE:   state_d = DECIDE;
         FINISH:   state_d = FINISH;
         ERROR:    state_d = ERROR;
         default:  state_d = IDLE;
      endcase
   end

   // btn_clk is derived from the next state so it is a clean flop output
   // that is high exactly while the FSM sits in PRESS_HI.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         btn_clk  <= 1'b0;
         pattern  <= '0;
         rounds   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         in_cnt   <= '0;
         lfsr     <= LFSR_SEED;
         hold_cnt <= '0;
         mode_q   <= '0;
      end else begin
         state_q <= state_d;
         btn_clk <= (state_d == PRESS_HI);
         if (state_d != state_q)                    hold_cnt <= '0;
         else if (state_q inside {PRESS_HI, PRESS_LO}) hold_cnt <= hold_cnt + 4'd1;
         case (state_q)
            IDLE: begin
               if (start) begin
                  wr_ptr <= '0;
                  rd_ptr <= '0;
                  in_cnt <= '0;
                  rounds <= '0;
               end
            end
            DECIDE: begin
               if (state_d == PRESS_HI) begin
                  mode_q <= mode_leds;
                  case (mode_leds)
                     MODE_INPUT: begin
                        pattern <= onehot4(lfsr[1:0]);
                        in_cnt  <= in_cnt + 7'd1;
                        lfsr    <= lfsr_step(lfsr);
                     end
                     MODE_PLAYBACK: wr_ptr <= wr_ptr + 7'd1;
                     MODE_REPEAT: begin
                        pattern <= rd_data;
                        rd_ptr  <= rd_ptr + 7'd1;
                     end
                     default: ;
                  endcase
               end
            end
            SETTLE: begin
               if (mode_q == MODE_REPEAT && mode_leds == MODE_PLAYBACK) begin
                  if (rounds != '1) rounds <= rounds + 7'd1;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end
               if (mode_q == MODE_PLAYBACK && mode_leds == MODE_REPEAT) rd_ptr <= '0;
               if (mode_q == MODE_INPUT && mode_leds != MODE_INPUT)     in_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign busy = !(state_q inside {IDLE, FINISH, ERROR});
   assign done = (state_q == FINISH);
   assign err  = (state_q == ERROR);

endmodule
